// File: rtl/count_60.sv
// count_60: two-digit packed-BCD modulo-60 counter with parallel load
// and terminal-count carry, for seconds/minutes stages of a clock chain.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, forces qout to 8'h00
//   ce    - count enable, present only with COUNT60_CLKEN_EN defined
//   ld    - synchronous parallel-load strobe, active high
//   data  - load value, packed BCD [7:4] tens, [3:0] units
//   qout  - current count, packed BCD 00..59
//   c     - carry, high while qout == 8'h59 (gated by ce when present)
//
// Optional feature macro: COUNT60_CLKEN_EN
module count_60 (
  input  logic       clk,
  input  logic       rst_n,
`ifdef COUNT60_CLKEN_EN
  input  logic       ce,
`endif
  input  logic       ld,
  input  logic [7:0] data,
  output logic [7:0] qout,
  output logic       c
);

  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] units_n;
  logic [3:0] tens_n;
  logic       adv;
  logic       data_ok;
  logic       at_top;

`ifdef COUNT60_CLKEN_EN
  assign adv = ce;
`else
  assign adv = 1'b1;
`endif

  assign data_ok = (data[3:0] <= 4'd9)
                && (data[7:4] <= 4'd5);

  assign qout   = {tens, units};
  assign at_top = (qout == 8'h59);

`ifdef COUNT60_CLKEN_EN
  assign c = at_top && ce;
`else
  assign c = at_top;
`endif

  // Load beats counting; an out-of-range load
  // value collapses to 00 rather than clamping.
  always_comb begin
    units_n = units;
    tens_n  = tens;
    unique case (1'b1)
      ld: begin
        if (data_ok) begin
          units_n = data[3:0];
          tens_n  = data[7:4];
        end else begin
          units_n = 4'd0;
          tens_n  = 4'd0;
        end
      end
      (!ld && adv): begin
        if (units == 4'd9) begin
          units_n = 4'd0;
          if (tens == 4'd5) begin
            tens_n = 4'd0;
          end else begin
            tens_n = tens + 4'd1;
          end
        end else begin
          units_n = units + 4'd1;
        end
      end
      default: begin
        units_n = units;
        tens_n  = tens;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else begin
      units <= units_n;
      tens  <= tens_n;
    end
  end

endmodule

// File: tb/tb_count_60.sv
// tb_count_60: randomized self-checking bench for count_60 against an
// integer-arithmetic reference model (default build, no ce port).
module tb_count_60;

  logic       clk;
  logic       rst_n;
  logic       ld;
  logic [7:0] data;
  logic [7:0] qout;
  logic       c;

  int passed;
  int total;
  int m;

  count_60 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .data  (data),
    .qout  (qout),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    int hi;
    int lo;
    hi = n / 10;
    lo = n % 10;
    return 8'(hi * 16 + lo);
  endfunction

  // Reference: count held as a plain integer 0..59.
  task automatic step(input string tag);
    int hi;
    int lo;
    @(posedge clk);
    hi = int'(data) / 16;
    lo = int'(data) % 16;
    if (ld) begin
      if (lo < 10 && hi < 6) m = hi * 10 + lo;
      else m = 0;
    end else begin
      m = (m + 1) % 60;
    end
    #1;
    check({tag, "_q"}, qout, bcd(m));
    check({tag, "_c"}, {7'd0, c}, {7'd0, m == 59});
  endtask

  task automatic load(input logic [7:0] v);
    ld   = 1'b1;
    data = v;
    step("ld");
    ld   = 1'b0;
  endtask

  initial begin
    int highs;
    passed = 0;
    total  = 0;
    rst_n  = 1'b1;
    ld     = 1'b0;
    data   = 8'h00;
    m      = 0;

    // Asynchronous reset between edges
    #1 rst_n = 1'b0;
    #2;
    check("rst_q", qout, 8'h00);
    check("rst_c", {7'd0, c}, 8'h00);
    #1 rst_n = 1'b1;

    // 01..10 with BCD carry
    for (int i = 1; i <= 10; i++) step("run");
    check("bcd10", qout, 8'h10);

    // Carry exactly once per 60 cycles
    highs = 0;
    for (int i = 0; i < 120; i++) begin
      step("wrap");
      if (c) highs++;
    end
    check("cper", 8'(highs), 8'd2);

    // Load 47 then count 48,49,50
    load(8'h47);
    check("ld47", qout, 8'h47);
    for (int i = 0; i < 3; i++) step("after47");
    check("to50", qout, 8'h50);

    // Load beats wrap at 59
    load(8'h59);
    check("ld59_c", {7'd0, c}, 8'h01);
    load(8'h23);
    check("ld23", qout, 8'h23);
    check("ld23_c", {7'd0, c}, 8'h00);

    // Invalid loads give 00
    load(8'h6A);
    check("ld6A", qout, 8'h00);
    step("inc");
    load(8'h3C);
    check("ld3C", qout, 8'h00);
    load(8'hA5);
    check("ldA5", qout, 8'h00);

    // ld pulse between edges is ignored
    data = 8'h33;
    #2 ld = 1'b1;
    #2 ld = 1'b0;
    step("glitch");
    check("glitch", qout, 8'h01);

    // Reset mid-count at 37
    load(8'h37);
    ld   = 1'b1;
    data = 8'h12;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst", qout, 8'h00);
    ld = 1'b0;
    #1 rst_n = 1'b1;
    m = 0;
    step("post_rst");
    check("post_rst1", qout, 8'h01);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        data = 8'($urandom);
      end else begin
        data = bcd(int'($urandom_range(0, 59)));
      end
      step("rnd");
    end
    ld = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end

endmodule

// File: doc/count_60.md
Name: count_60

Overview:
- Synchronous two-digit BCD modulo-60 counter (00..59) with parallel load and terminal-count carry.
- Used as the seconds/minutes stage of a clock chain. The carry `c` feeds the next stage's count enable.
- Single clock domain. Asynchronous active-low reset.

Parameters:
- None. The modulus is fixed at 60 and the encoding is fixed as packed BCD.

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  asynchronous active-low reset
- ld     input   1  synchronous parallel-load strobe, active high
- data   input   8  load value, packed BCD: [7:4] tens, [3:0] units
- qout   output  8  current count, packed BCD: [7:4] tens 0..5, [3:0] units 0..9
- c      output  1  carry/terminal count, high while qout == 8'h59

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset
  - rst_n low forces qout = 8'h00 immediately, independent of clk, so c = 0.
  - Reset dominates ld and counting.
  - Release is synchronous in effect: counting resumes at the first posedge with rst_n high.
- Priority at each posedge clk (rst_n high): ld > count.
- Load (ld = 1 at posedge)
  - If data is valid BCD in range (data[3:0] <= 9 and data[7:4] <= 5), then qout <= data.
  - Otherwise qout <= 8'h00. No partial clamping.
  - A load at 59 overrides the wrap.
  - ld is sampled only at posedge clk. A pulse that does not span a rising edge has no effect.
- Count (ld = 0)
  - Units increment each posedge.
  - Units 9 -> 0 with tens +1.
  - 8'h59 -> 8'h00 (wrap). No illegal state is ever reachable.
- Carry `c`
  - Combinational: c = (qout == 8'h59).
  - High for exactly one clock period per 60-cycle revolution.
  - Also high after a load of 8'h59.
- Latency: qout changes one posedge after ld or count; c follows qout with no extra delay.
- Reset mid-operation: qout returns to 00 asynchronously; any pending load is discarded.

Optional Feature:
- Macro: COUNT60_CLKEN_EN
- Defined
  - Adds input port `ce` (1 bit) after rst_n.
  - Counting advances only on posedges where ce = 1. ld still loads regardless of ce.
  - c = (qout == 8'h59) && ce, so stages can be cascaded by wiring c to the next stage's ce.
- Undefined
  - No ce port. Counts every clock.
  - c as specified in Behaviour.

Test Plan:
- Pulse rst_n low 5 ns while clk idle -> qout = 8'h00 and c = 0 immediately. Released with ld = 0 -> qout 01, 02 … 09, 10 on successive posedges (BCD carry, never 0A).
- Free-run 60 cycles from 00 -> qout reaches 8'h59 with c = 1 for exactly one cycle; next posedge qout = 8'h00, c = 0. Repeats with period 60.
- data = 8'h47, ld = 1 held across one posedge -> qout = 8'h47; ld low -> 48, 49, 50 on the next three edges.
- With qout = 8'h59, load data = 8'h23 -> qout = 8'h23 (load beats wrap), c drops. Load 8'h6A or 8'h3C -> qout = 8'h00.
- ld pulsed high and low between posedges -> qout unaffected, keeps counting.
- Assert rst_n mid-count at qout = 8'h37 -> qout = 8'h00 before the next edge. With COUNT60_CLKEN_EN and ce = 0 for 3 edges -> qout holds; c gated low at 59.
